// File: rtl/vrf_pkg.sv
// vrf_pkg: shared constants, vector type and stream-address helper for the vector register file
package vrf_pkg;
    localparam int DEF_WIDTH_ADDR   = 4;
    localparam int DEF_WIDTH_VECTOR = 8;
    localparam int DEF_N            = 32;
    localparam int DEF_N_RD         = 2;
    localparam int DEF_WA_FIFO      = 3;
    localparam int ADDR_IN          = 0;
    typedef logic [DEF_WIDTH_VECTOR-1:0][DEF_N-1:0] vec_t;
    function automatic int addr_out(input int width_addr);
        return (1 << width_addr) - 1;
    endfunction
endpackage

// File: rtl/vec_reg_file_stream_if.sv
// vec_reg_file_stream_if: decoder/lane-side read, write and stream signals of the register file
interface vec_reg_file_stream_if import vrf_pkg::*; #(
    parameter int WIDTH_ADDR   = DEF_WIDTH_ADDR,
    parameter int WIDTH_VECTOR = DEF_WIDTH_VECTOR,
    parameter int N            = DEF_N,
    parameter int N_RD         = DEF_N_RD,
    parameter int WA_FIFO      = DEF_WA_FIFO
);
    logic                                      rd_req;
    logic [N_RD*WIDTH_ADDR-1:0]                rd_addr;
    logic                                      rd_stall;
    logic                                      rd_valid;
    logic [N_RD-1:0][WIDTH_VECTOR-1:0][N-1:0]  rd_data;
    logic [WIDTH_VECTOR-1:0]                   wr_en;
    logic [WIDTH_ADDR-1:0]                     wr_addr;
    logic [WIDTH_VECTOR-1:0][N-1:0]            wr_data;
    logic                                      wr_stall;
    logic [WIDTH_VECTOR-1:0][N-1:0]            in_data;
    logic                                      in_valid;
    logic                                      in_ready;
    logic [WIDTH_VECTOR-1:0][N-1:0]            out_data;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [WA_FIFO:0]                          in_level;
    logic [WA_FIFO:0]                          out_level;
    logic                                      err_wr0;
    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data, in_data, in_valid, out_ready,
        input  rd_stall, rd_valid, rd_data, wr_stall, in_ready, out_data, out_valid,
               in_level, out_level, err_wr0
    );
    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data, in_data, in_valid, out_ready,
        output rd_stall, rd_valid, rd_data, wr_stall, in_ready, out_data, out_valid,
               in_level, out_level, err_wr0
    );
endinterface

// File: rtl/vrf_sync_fifo.sv
// vrf_sync_fifo: single-clock FIFO, registered storage, no fall-through, occupancy output
module vrf_sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             push,
    output logic             full,
    output logic [DSIZE-1:0] rdata,
    input  logic             pop,
    output logic             empty,
    output logic [ASIZE:0]   level
);
    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr, rptr;
    logic             do_push, do_pop;
    // extra pointer MSB distinguishes full from empty when the index bits match
    assign full    = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign empty   = wptr == rptr;
    assign level   = wptr - rptr;
    assign rdata   = mem[rptr[ASIZE-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < 2**ASIZE; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[ASIZE-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/vec_reg_file_stream.sv
// vec_reg_file_stream: multi-read-port vector register file with write-first bypass;
// address 0 reads pop the input stream, the top address writes push the output stream
module vec_reg_file_stream import vrf_pkg::*; #(
    parameter int WIDTH_ADDR   = DEF_WIDTH_ADDR,
    parameter int WIDTH_VECTOR = DEF_WIDTH_VECTOR,
    parameter int N            = DEF_N,
    parameter int N_RD         = DEF_N_RD,
    parameter int WA_FIFO      = DEF_WA_FIFO
) (
    input logic clk,
    input logic rst,
    vec_reg_file_stream_if.slave bus
);
    localparam int NREG  = 2**WIDTH_ADDR;
    localparam int DSIZE = WIDTH_VECTOR*N;
    localparam logic [WIDTH_ADDR-1:0] A_IN  = WIDTH_ADDR'(ADDR_IN);
    localparam logic [WIDTH_ADDR-1:0] A_OUT = WIDTH_ADDR'(addr_out(WIDTH_ADDR));
    typedef logic [WIDTH_VECTOR-1:0][N-1:0] lvec_t;
    lvec_t regs [NREG];
    lvec_t in_head, out_push_data;
    logic [N_RD-1:0][WIDTH_VECTOR-1:0][N-1:0] rd_mux, rd_q;
    logic [N_RD-1:0] is_in;
    logic rd_acc, rd_valid_q, err_q;
    logic wr_any, wr_to_out, wr_acc, wr_to_reg;
    logic in_full, in_empty, out_full, out_empty;
    assign bus.rd_stall = bus.rd_req && (|is_in) && in_empty;
    assign rd_acc       = bus.rd_req && !bus.rd_stall;
    assign wr_any       = |bus.wr_en;
    assign wr_to_out    = bus.wr_addr == A_OUT;
    assign bus.wr_stall = wr_to_out && wr_any && out_full;
    assign wr_acc       = wr_any && !bus.wr_stall;
    assign wr_to_reg    = wr_acc && !wr_to_out && (bus.wr_addr != A_IN);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_q;
    assign bus.err_wr0  = err_q;
    assign bus.in_ready = !in_full;
    assign bus.out_valid = !out_empty;
    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [WIDTH_ADDR-1:0] a;
        lvec_t nxt;
        assign a         = bus.rd_addr[p*WIDTH_ADDR +: WIDTH_ADDR];
        assign is_in[p]  = a == A_IN;
        assign rd_mux[p] = nxt;
        // stream addresses override the array; same-address writes bypass per lane
        always_comb begin
            nxt = regs[a];
            for (int i = 0; i < WIDTH_VECTOR; i++)
                if (wr_to_reg && bus.wr_addr == a && bus.wr_en[i]) nxt[i] = bus.wr_data[i];
            if (is_in[p]) nxt = in_head;
            if (a == A_OUT) nxt = '0;
        end
    end
    always_comb begin
        out_push_data = '0;
        for (int i = 0; i < WIDTH_VECTOR; i++)
            out_push_data[i] = bus.wr_en[i] ? bus.wr_data[i] : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else if (wr_to_reg) begin
            for (int i = 0; i < WIDTH_VECTOR; i++)
                if (bus.wr_en[i]) regs[bus.wr_addr][i] <= bus.wr_data[i];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_q <= rd_mux;
            if (wr_any && bus.wr_addr == A_IN) err_q <= 1'b1;
        end
    end
    // one pop per accepted read regardless of how many ports name address 0
    vrf_sync_fifo #(.DSIZE(DSIZE), .ASIZE(WA_FIFO)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (bus.in_data),
        .push  (bus.in_valid),
        .full  (in_full),
        .rdata (in_head),
        .pop   (rd_acc && (|is_in)),
        .empty (in_empty),
        .level (bus.in_level)
    );
    vrf_sync_fifo #(.DSIZE(DSIZE), .ASIZE(WA_FIFO)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (out_push_data),
        .push  (wr_acc && wr_to_out),
        .full  (out_full),
        .rdata (bus.out_data),
        .pop   (bus.out_ready),
        .empty (out_empty),
        .level (bus.out_level)
    );
endmodule

// File: tb/tb_vec_reg_file_stream.sv
// tb_vec_reg_file_stream: table-driven stimulus with queue-based model and read scoreboard
module tb_vec_reg_file_stream;
    import vrf_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    vec_reg_file_stream_if bus ();
    vec_reg_file_stream dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic        rd_req;
        logic [3:0]  a0, a1;
        logic [7:0]  wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_pat, wr_inc;
        logic        in_valid;
        logic [31:0] in_pat;
        logic        out_ready;
        logic        exp_rs, exp_ws;
    } vec_rec_t;
    typedef struct { vec_t v0; vec_t v1; } rd_exp_t;
    int n_chk = 0;
    int n_fail = 0;
    vec_t m_regs [16];
    vec_t m_in [$];
    vec_t m_out [$];
    logic m_err;
    rd_exp_t rd_q [$];
    vec_rec_t tbl [$];

    function automatic vec_t mkvec(input logic [31:0] pat, input logic [31:0] inc);
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = pat + inc * 32'(i);
        return v;
    endfunction

    function automatic vec_rec_t mk(input bit rq, input int a0, input int a1, input int wen,
                                    input int wa, input logic [31:0] wp, input logic [31:0] wi,
                                    input bit iv, input logic [31:0] ip, input bit ordy,
                                    input bit rs, input bit ws);
        vec_rec_t r;
        r.rd_req = rq; r.a0 = 4'(a0); r.a1 = 4'(a1); r.wr_en = 8'(wen); r.wr_addr = 4'(wa);
        r.wr_pat = wp; r.wr_inc = wi; r.in_valid = iv; r.in_pat = ip; r.out_ready = ordy;
        r.exp_rs = rs; r.exp_ws = ws;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_in.delete();
        m_out.delete();
        rd_q.delete();
        m_err = 1'b0;
    endtask

    task automatic idle();
        bus.rd_req = 0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    endtask

    function automatic vec_t model_rd(input logic [3:0] a, input logic wreg, input logic [3:0] wa,
                                      input logic [7:0] wen, input vec_t wv);
        vec_t v;
        if (a == 4'd0) return m_in[0];
        if (a == 4'd15) return '0;
        v = m_regs[a];
        if (wreg && wa == a)
            for (int i = 0; i < 8; i++) if (wen[i]) v[i] = wv[i];
        return v;
    endfunction

    task automatic run(input vec_rec_t r);
        vec_t wv, iv, mv;
        logic rs, ws, wreg, acc;
        int in_sz0;
        rd_exp_t e;
        wv = mkvec(r.wr_pat, r.wr_inc);
        iv = mkvec(r.in_pat, 32'd1);
        bus.rd_req = r.rd_req; bus.rd_addr = {r.a1, r.a0};
        bus.wr_en = r.wr_en; bus.wr_addr = r.wr_addr; bus.wr_data = wv;
        bus.in_valid = r.in_valid; bus.in_data = iv; bus.out_ready = r.out_ready;
        #1;
        chk("rd_stall", 256'(bus.rd_stall), 256'(r.exp_rs));
        chk("wr_stall", 256'(bus.wr_stall), 256'(r.exp_ws));
        chk("in_level", 256'(bus.in_level), 256'(m_in.size()));
        chk("out_level", 256'(bus.out_level), 256'(m_out.size()));
        chk("in_ready", 256'(bus.in_ready), 256'(m_in.size() < 8));
        chk("out_valid", 256'(bus.out_valid), 256'(m_out.size() > 0));
        chk("err_wr0", 256'(bus.err_wr0), 256'(m_err));
        if (m_out.size() > 0) chk("out_data", bus.out_data, m_out[0]);
        in_sz0 = m_in.size();
        rs = r.rd_req && (r.a0 == 0 || r.a1 == 0) && in_sz0 == 0;
        ws = r.wr_addr == 4'd15 && (|r.wr_en) && m_out.size() == 8;
        wreg = (|r.wr_en) && !ws && r.wr_addr != 4'd0 && r.wr_addr != 4'd15;
        acc = r.rd_req && !rs;
        if (acc) begin
            e.v0 = model_rd(r.a0, wreg, r.wr_addr, r.wr_en, wv);
            e.v1 = model_rd(r.a1, wreg, r.wr_addr, r.wr_en, wv);
            rd_q.push_back(e);
            if (r.a0 == 0 || r.a1 == 0) m_in.delete(0);
        end
        if (wreg)
            for (int i = 0; i < 8; i++) if (r.wr_en[i]) m_regs[r.wr_addr][i] = wv[i];
        if ((|r.wr_en) && r.wr_addr == 4'd0) m_err = 1'b1;
        if (r.out_ready && m_out.size() > 0) m_out.delete(0);
        if ((|r.wr_en) && r.wr_addr == 4'd15 && !ws) begin
            for (int i = 0; i < 8; i++) mv[i] = r.wr_en[i] ? wv[i] : 32'd0;
            m_out.push_back(mv);
        end
        if (r.in_valid && in_sz0 < 8) m_in.push_back(iv);
        @(posedge clk);
        #1;
        chk("rd_valid", 256'(bus.rd_valid), 256'(acc));
        if (acc && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("rd_data0", bus.rd_data[0], e.v0);
            chk("rd_data1", bus.rd_data[1], e.v1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("rst_rd_data", 256'(bus.rd_data), 256'(0));
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_levels", 256'({bus.in_level, bus.out_level}), 256'(0));
        chk("rst_err", 256'(bus.err_wr0), 256'(0));
        rst = 1'b0;

        tbl.push_back(mk(0, 0, 0, 'hFF, 5, 'h1111_1111, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'hFF, 3, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 3, 'h0F, 5, 'hAAAA_AAAA, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 1, 'h55, 0, 1, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hB0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'hFF, 0, 'hDEAD, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 0, 'hFF, 15, 'h100 * k, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h3C, 15, 'h999, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 'h3C, 15, 'h999, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 'h3C, 15, 'h999, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 15, 7, 'h81, 7, 'h7777, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 9; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 9; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hC0 + 'h10 * k, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) run(tbl[i]);

        // explicit constant checks: plain write/read and partial-lane bypass
        run(mk(0, 0, 0, 'hFF, 3, 1, 1, 0, 0, 0, 0, 0));
        run(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) chk("t1_lane", 256'(bus.rd_data[1][i]), 256'(i + 1));
        run(mk(0, 0, 0, 'hFF, 5, 'h1111_1111, 0, 0, 0, 0, 0, 0));
        run(mk(1, 5, 5, 'h0F, 5, 'hAAAA_AAAA, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            chk("t2_lane", 256'(bus.rd_data[0][i]), 256'(i < 4 ? 32'hAAAA_AAAA : 32'h1111_1111));

        // reset in the middle of traffic with both FIFOs occupied and a read in flight
        run(mk(0, 0, 0, 'hFF, 15, 'h42, 0, 1, 'hE0, 0, 0, 0));
        run(mk(1, 3, 5, 0, 0, 0, 0, 1, 'hF0, 0, 0, 0));
        chk("pre_rst_valid", 256'(bus.rd_valid), 256'(1));
        idle();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("mid_rst_rd_data", 256'(bus.rd_data), 256'(0));
        chk("mid_rst_in_level", 256'(bus.in_level), 256'(0));
        chk("mid_rst_out_level", 256'(bus.out_level), 256'(0));
        chk("mid_rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("mid_rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("mid_rst_err", 256'(bus.err_wr0), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        run(mk(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
